gol_run_scheduler: RTL and testbench
====================================

Name: gol_run_scheduler

Overview:
- Run controller for the Game of Life datapath. Sits between the user switches and the grid register.
- Sequences setup, run, pause, single-step and halt. Produces the one-cycle enable_update strobe that commits grid_next into grid.
- Programmable generation rate. Counts generations.
- Auto-halts when the board goes extinct or reaches a still life.

Parameters:
- GRID_N, 16, grid edge length; the grid buses are GRID_N x GRID_N.
- GEN_W, 16, generation counter width.
- RATE_W, 3, width of rate_sel; generation period is 2^rate_sel clk cycles.

Ports:
- clk  input  1  slow game clock (divided clock domain)
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  level run switch; rising edge begins a run, low returns to setup
- pause  input  1  level; high holds the game in PAUSE
- step_req  input  1  rising edge in PAUSE issues exactly one generation
- rate_sel  input  RATE_W  generation period select
- grid  input  [GRID_N-1:0][GRID_N-1:0]  current board
- grid_next  input  [GRID_N-1:0][GRID_N-1:0]  next board from update logic
- enable_update  output  1  one-cycle commit strobe to grid
- state  output  3  encoded FSM state (package enum)
- generation  output  GEN_W  generations committed since run start
- halted  output  1  high while in HALT
- halt_reason  output  2  0 none, 1 extinct, 2 still, 3 period-2

Behaviour:
- Reset values: state=IDLE, enable_update=0, generation=0, halted=0, halt_reason=0, period counter=0, edge registers=0.
- States:
  - IDLE (setup; the user edits cells).
  - RUN.
  - PAUSE.
  - HALT.
- start and step_req are edge-detected with a registered previous value. The edge is visible one cycle after the input rises.
- IDLE -> RUN on start rising edge. On entry: generation=0, period counter=0, halt_reason=0.
- start low in RUN, PAUSE or HALT -> IDLE next cycle. This has top priority over every other event.
- RUN -> PAUSE when pause=1. Pause outranks a same-cycle period expiry, so no strobe is issued.
- PAUSE -> RUN when pause=0. The period counter restarts at 0.
- Period counter:
  - Increments each RUN cycle.
  - Expiry occurs when count == (1<<rate_sel)-1; the counter then wraps to 0.
  - rate_sel=0 means expiry every cycle.
  - A rate_sel change mid-count takes effect on the next comparison. If count already exceeds the new limit, treat it as expiry.
- At expiry, or on a PAUSE step edge, run the halt check in this priority order:
  - grid all zero -> HALT, reason 1, no strobe.
  - grid_next == grid -> HALT, reason 2, no strobe.
  - Otherwise, enable_update=1 for exactly one cycle.
- generation increments on the cycle enable_update is high and saturates at 2^GEN_W-1.
- A step_req edge in RUN, IDLE or HALT is ignored.
- A step in PAUSE stays in PAUSE, unless the halt check fires, which moves to HALT.
- HALT holds generation and halt_reason. halted=1. It leaves only via start low.
- enable_update is registered with zero latency from the decision cycle and is never high in IDLE, PAUSE (except a step) or HALT.
- Asynchronous reset mid-run aborts immediately and returns all outputs to reset values.

Optional Feature:
- Macro: GOL_PERIOD2_DETECT_EN.
- When defined:
  - An internal prev_grid register captures grid on every enable_update.
  - It is cleared on run start.
  - An additional halt check runs after the still-life check: generation>=2 and grid_next == prev_grid -> HALT, reason 3, no strobe.
  - This catches blinkers.
- When undefined: no prev_grid register exists, and reason 3 is never produced.

Decomposition:
- gol_pkg holds:
  - GRID_N.
  - typedef grid_t (packed 2-D GRID_N x GRID_N).
  - enum sched_state_t {IDLE, RUN, PAUSE, HALT}.
  - enum halt_reason_t {HR_NONE, HR_EXTINCT, HR_STILL, HR_OSC2}.
- Sub-module gol_rate_timer implements the period counter:
  - Inputs: clk, reset, clear, run, rate_sel.
  - Output: expire.
- Comparison logic and the FSM stay in the top module.

Test Plan:
- Reset with start=1 held: outputs at reset values. Release reset, toggle start 0->1 -> state=RUN within 2 cycles, generation=0.
- rate_sel=2 with a glider loaded: enable_update pulses every 4 cycles. After 5 pulses, generation=5.
- pause=1 in RUN: no strobes for 20 cycles. Then three step_req edges -> exactly 3 single-cycle strobes, generation +3, state remains PAUSE.
- Block (2x2 still life), rate_sel=0: first expiry -> no strobe, HALT, halt_reason=2, generation=0. Drop start -> IDLE next cycle.
- Single isolated cell: first strobe, then grid empty -> HALT reason 1, generation=1.
- Blinker, only with GOL_PERIOD2_DETECT_EN: HALT reason 3 at generation=2. Without the macro: runs indefinitely, generation keeps counting. Asserting reset mid-run clears everything asynchronously.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types for the Game of Life run scheduler: board type, FSM states and halt reasons.
package gol_pkg;

  localparam int GRID_N = 16;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    HALT  = 3'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    HR_NONE    = 2'd0,
    HR_EXTINCT = 2'd1,
    HR_STILL   = 2'd2,
    HR_OSC2    = 2'd3
  } halt_reason_t;

endpackage

// File: rtl/gol_rate_timer.sv
// Generation period counter: expires every 2^rate_sel run cycles, wraps on expiry.
module gol_rate_timer #(
  parameter int RATE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic [RATE_W-1:0] rate_sel,
  output logic              expire
);
  import gol_pkg::*;

  localparam int CNT_W = (1 << RATE_W) - 1;
  localparam logic [CNT_W-1:0] ONES = '1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  // >= rather than == so that lowering rate_sel below the current count expires at once
  always_comb begin
    limit  = ONES >> (RATE_W'(CNT_W) - rate_sel);
    expire = run && (count >= limit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/gol_run_scheduler.sv
// Run controller for the Game of Life grid: setup/run/pause/step/halt with auto-halt detection.
// Optional blinker (period-2) halt check enabled by defining GOL_PERIOD2_DETECT_EN.
module gol_run_scheduler #(
  parameter int GRID_N = 16,
  parameter int GEN_W  = 16,
  parameter int RATE_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          step_req,
  input  logic [RATE_W-1:0]             rate_sel,
  input  logic [GRID_N-1:0][GRID_N-1:0] grid,
  input  logic [GRID_N-1:0][GRID_N-1:0] grid_next,
  output logic                          enable_update,
  output logic [2:0]                    state,
  output logic [GEN_W-1:0]              generation,
  output logic                          halted,
  output logic [1:0]                    halt_reason
);
  import gol_pkg::*;

  sched_state_t state_q, state_d;
  halt_reason_t reason_q, reason_d;
  logic [GEN_W-1:0] gen_q;
  logic start_q, step_q;
  logic start_rise, step_rise;
  logic expire, tmr_run, tmr_clear;
  logic decide, run_start;
  logic extinct, still, osc2;

  assign start_rise = start && !start_q;
  assign step_rise  = step_req && !step_q;
  assign tmr_run    = (state_q == RUN) && start && !pause;
  assign tmr_clear  = (state_q != RUN);
  assign extinct    = (grid == '0);
  assign still      = (grid_next == grid);

  gol_rate_timer #(.RATE_W(RATE_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .run      (tmr_run),
    .rate_sel (rate_sel),
    .expire   (expire)
  );

`ifdef GOL_PERIOD2_DETECT_EN
  logic [GRID_N-1:0][GRID_N-1:0] prev_grid;

  assign osc2 = (gen_q >= GEN_W'(2)) && (grid_next == prev_grid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_grid <= '0;
    end else if (run_start) begin
      prev_grid <= '0;
    end else if (enable_update) begin
      prev_grid <= grid;
    end
  end
`else
  assign osc2 = 1'b0;
`endif

  // start low beats everything; pause beats a same-cycle expiry
  always_comb begin
    state_d       = state_q;
    reason_d      = reason_q;
    enable_update = 1'b0;
    decide        = 1'b0;
    run_start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = RUN;
          reason_d  = HR_NONE;
          run_start = 1'b1;
        end
      end
      RUN: begin
        if (!start)      state_d = IDLE;
        else if (pause)  state_d = PAUSE;
        else if (expire) decide  = 1'b1;
      end
      PAUSE: begin
        if (!start)         state_d = IDLE;
        else if (step_rise) decide  = 1'b1;
        else if (!pause)    state_d = RUN;
      end
      HALT: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (decide) begin
      if (extinct) begin
        state_d  = HALT;
        reason_d = HR_EXTINCT;
      end else if (still) begin
        state_d  = HALT;
        reason_d = HR_STILL;
      end else if (osc2) begin
        state_d  = HALT;
        reason_d = HR_OSC2;
      end else begin
        enable_update = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      reason_q <= HR_NONE;
      gen_q    <= '0;
      start_q  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      start_q  <= start;
      step_q   <= step_req;
      if (run_start) begin
        gen_q <= '0;
      end else if (enable_update && (gen_q != '1)) begin
        gen_q <= gen_q + 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign generation  = gen_q;
  assign halted      = (state_q == HALT);
  assign halt_reason = reason_q;

endmodule

// File: tb/tb_gol_run_scheduler.sv
// Self-checking bench for gol_run_scheduler: closed-loop board plus a generation-level reference model.
module tb_gol_run_scheduler;
  import gol_pkg::*;

  localparam int N      = GRID_N;
  localparam int GEN_W  = 16;
  localparam int RATE_W = 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic              pause;
  logic              step_req;
  logic [RATE_W-1:0] rate_sel;
  grid_t             board;
  grid_t             board_next;
  logic              enable_update;
  logic [2:0]        state;
  logic [GEN_W-1:0]  generation;
  logic              halted;
  logic [1:0]        halt_reason;

  logic  load_en;
  grid_t load_val;
  int    tests_run;
  int    fails;
  int    strobe_cnt;

  gol_run_scheduler #(.GRID_N(N), .GEN_W(GEN_W), .RATE_W(RATE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .step_req      (step_req),
    .rate_sel      (rate_sel),
    .grid          (board),
    .grid_next     (board_next),
    .enable_update (enable_update),
    .state         (state),
    .generation    (generation),
    .halted        (halted),
    .halt_reason   (halt_reason)
  );

  // Conway rules on a bounded board (cells outside are dead)
  function automatic grid_t life(input grid_t g);
    grid_t n;
    int cnt;
    n = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < N) &&
                (c + dc >= 0) && (c + dc < N)) begin
              if (g[r+dr][c+dc]) cnt++;
            end
          end
        end
        n[r][c] = (cnt == 3) || (cnt == 2 && g[r][c]);
      end
    end
    return n;
  endfunction

  assign board_next = life(board);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en)            board <= load_val;
    else if (enable_update) board <= board_next;
  end

  always @(negedge clk) begin
    if (enable_update) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_board(input grid_t b);
    load_val = b;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    start = 1'b0;
    tick();
    tests_run++;
    if (state !== 3'(IDLE)) begin
      fails++;
      $display("FAIL %s idle_state got=%0d exp=%0d", tag, state, IDLE);
    end
    tests_run++;
    if (enable_update !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_strobe got=%0b exp=0", tag, enable_update);
    end
  endtask

  // Predicts, generation by generation, which run cycles strobe and when the board halts,
  // then starts a run from IDLE and checks every cycle up to n.
  task automatic run_check(input grid_t b0, input int r, input int n, input string tag);
    grid_t bk, bprev, bn;
    int strobe_c[$];
    int halt_c, reason, p, si, exp_gen;
    logic exp_en;
    logic [2:0] exp_st;
    p = 1 << r;
    bk = b0;
    bprev = '0;
    halt_c = -1;
    reason = 0;
    for (int k = 0; k * p + p - 1 < n; k++) begin
      bn = life(bk);
      if (bk == '0) begin
        halt_c = k * p + p - 1; reason = 1; break;
      end
      if (bn == bk) begin
        halt_c = k * p + p - 1; reason = 2; break;
      end
`ifdef GOL_PERIOD2_DETECT_EN
      if (k >= 2 && bn == bprev) begin
        halt_c = k * p + p - 1; reason = 3; break;
      end
`endif
      strobe_c.push_back(k * p + p - 1);
      bprev = bk;
      bk = bn;
    end

    pause    = 1'b0;
    step_req = 1'b0;
    rate_sel = RATE_W'(r);
    load_board(b0);
    start = 1'b1;
    tick();
    si = 0;
    exp_gen = 0;
    for (int c = 0; c < n; c++) begin
      exp_en = (si < strobe_c.size()) && (strobe_c[si] == c);
      exp_st = (halt_c >= 0 && c > halt_c) ? 3'(HALT) : 3'(RUN);
      tests_run++;
      if (enable_update !== exp_en) begin
        fails++;
        $display("FAIL %s strobe c=%0d got=%0b exp=%0b", tag, c, enable_update, exp_en);
      end
      tests_run++;
      if (state !== exp_st) begin
        fails++;
        $display("FAIL %s state c=%0d got=%0d exp=%0d", tag, c, state, exp_st);
      end
      tests_run++;
      if (generation !== GEN_W'(exp_gen)) begin
        fails++;
        $display("FAIL %s generation c=%0d got=%0d exp=%0d", tag, c, generation, exp_gen);
      end
      if (exp_en) begin
        si++;
        exp_gen++;
      end
      tick();
    end
    tests_run++;
    if (generation !== GEN_W'(exp_gen)) begin
      fails++;
      $display("FAIL %s final_generation got=%0d exp=%0d", tag, generation, exp_gen);
    end
    tests_run++;
    if (halted !== (halt_c >= 0)) begin
      fails++;
      $display("FAIL %s halted got=%0b exp=%0b", tag, halted, halt_c >= 0);
    end
    tests_run++;
    if (halt_reason !== 2'(reason)) begin
      fails++;
      $display("FAIL %s halt_reason got=%0d exp=%0d", tag, halt_reason, reason);
    end
  endtask

  function automatic grid_t glider();
    grid_t g;
    g = '0;
    g[1][2] = 1'b1;
    g[2][3] = 1'b1;
    g[3][1] = 1'b1;
    g[3][2] = 1'b1;
    g[3][3] = 1'b1;
    return g;
  endfunction

  function automatic grid_t rand_board();
    grid_t g;
    g = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        g[r][c] = ($urandom_range(0, 2) == 0);
    return g;
  endfunction

  task automatic test_reset;
    bit seen;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (state !== 3'(IDLE)) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests_run++;
    if (enable_update !== 1'b0) begin fails++; $display("FAIL reset_strobe got=%0b exp=0", enable_update); end
    tests_run++;
    if (generation !== '0) begin fails++; $display("FAIL reset_generation got=%0d exp=0", generation); end
    tests_run++;
    if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    tests_run++;
    if (halt_reason !== 2'd0) begin fails++; $display("FAIL reset_reason got=%0d exp=0", halt_reason); end
    start = 1'b0;
    load_board(glider());
    reset = 1'b0;
    tick();
    tests_run++;
    if (state !== 3'(IDLE)) begin fails++; $display("FAIL post_reset_idle got=%0d exp=0", state); end
    rate_sel = 3'd4;
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      seen = (state === 3'(RUN));
    end
    tests_run++;
    if (!seen) begin fails++; $display("FAIL start_to_run got=%0d exp=%0d", state, RUN); end
    tests_run++;
    if (generation !== '0) begin fails++; $display("FAIL start_generation got=%0d exp=0", generation); end
    go_idle("reset");
  endtask

  task automatic test_glider_rate;
    run_check(glider(), 2, 20, "glider_r2");
    go_idle("glider_r2");
  endtask

  task automatic test_pause_step;
    int cnt0;
    run_check(glider(), 1, 6, "pause_run");
    pause = 1'b1;
    cnt0 = strobe_cnt;
    repeat (21) tick();
    tests_run++;
    if (strobe_cnt !== cnt0) begin fails++; $display("FAIL pause_no_strobe got=%0d exp=%0d", strobe_cnt - cnt0, 0); end
    tests_run++;
    if (state !== 3'(PAUSE)) begin fails++; $display("FAIL pause_state got=%0d exp=%0d", state, PAUSE); end
    tests_run++;
    if (generation !== GEN_W'(3)) begin fails++; $display("FAIL pause_generation got=%0d exp=3", generation); end
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick();
    end
    tick();
    tests_run++;
    if (strobe_cnt !== cnt0 + 3) begin fails++; $display("FAIL step_strobes got=%0d exp=3", strobe_cnt - cnt0); end
    tests_run++;
    if (generation !== GEN_W'(6)) begin fails++; $display("FAIL step_generation got=%0d exp=6", generation); end
    tests_run++;
    if (state !== 3'(PAUSE)) begin fails++; $display("FAIL step_state got=%0d exp=%0d", state, PAUSE); end
    pause = 1'b0;
    tick();
    tests_run++;
    if (state !== 3'(RUN)) begin fails++; $display("FAIL resume_state got=%0d exp=%0d", state, RUN); end
    go_idle("pause");
  endtask

  task automatic test_still_life;
    grid_t b;
    int cnt0;
    b = '0;
    b[5][5] = 1'b1; b[5][6] = 1'b1; b[6][5] = 1'b1; b[6][6] = 1'b1;
    run_check(b, 0, 4, "block");
    cnt0 = strobe_cnt;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    tests_run++;
    if (strobe_cnt !== cnt0) begin fails++; $display("FAIL halt_step_ignored got=%0d exp=0", strobe_cnt - cnt0); end
    tests_run++;
    if (state !== 3'(HALT)) begin fails++; $display("FAIL halt_hold got=%0d exp=%0d", state, HALT); end
    go_idle("block");
  endtask

  task automatic test_extinct;
    grid_t b;
    b = '0;
    b[8][8] = 1'b1;
    run_check(b, 1, 6, "single_cell");
    go_idle("single_cell");
  endtask

  task automatic test_blinker;
    grid_t b;
    b = '0;
    b[7][6] = 1'b1; b[7][7] = 1'b1; b[7][8] = 1'b1;
    run_check(b, 0, 10, "blinker");
    go_idle("blinker");
  endtask

  task automatic test_rate_change;
    run_check(glider(), 3, 5, "rate_change");
    rate_sel = 3'd1;
    #1;
    tests_run++;
    if (enable_update !== 1'b1) begin fails++; $display("FAIL rate_drop_expire got=%0b exp=1", enable_update); end
    tick();
    tests_run++;
    if (enable_update !== 1'b0) begin fails++; $display("FAIL rate_wrap got=%0b exp=0", enable_update); end
    tick();
    tests_run++;
    if (enable_update !== 1'b1) begin fails++; $display("FAIL rate_new_period got=%0b exp=1", enable_update); end
    go_idle("rate_change");
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      run_check(rand_board(), $urandom_range(0, 2), $urandom_range(8, 40), $sformatf("random%0d", i));
      go_idle("random");
    end
  endtask

  task automatic test_reset_midrun;
    run_check(glider(), 0, 3, "midrun");
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (state !== 3'(IDLE)) begin fails++; $display("FAIL midrun_state got=%0d exp=0", state); end
    tests_run++;
    if (generation !== '0) begin fails++; $display("FAIL midrun_generation got=%0d exp=0", generation); end
    tests_run++;
    if (enable_update !== 1'b0) begin fails++; $display("FAIL midrun_strobe got=%0b exp=0", enable_update); end
    tests_run++;
    if (halted !== 1'b0 || halt_reason !== 2'd0) begin
      fails++;
      $display("FAIL midrun_halt got=%0b/%0d exp=0/0", halted, halt_reason);
    end
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (state !== 3'(IDLE)) begin fails++; $display("FAIL midrun_after got=%0d exp=0", state); end
  endtask

  initial begin
    tests_run  = 0;
    fails      = 0;
    strobe_cnt = 0;
    reset      = 1'b1;
    start      = 1'b0;
    pause      = 1'b0;
    step_req   = 1'b0;
    rate_sel   = '0;
    load_en    = 1'b0;
    load_val   = '0;
    board      = '0;
    test_reset();
    test_glider_rate();
    test_pause_step();
    test_still_life();
    test_extinct();
    test_blinker();
    test_rate_change();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
